// File: rtl/regc_pkg.sv
// Shared constants, state encoding and the count-clamp helper for the
// register-C sweep sequencer.
package regc_pkg;

    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 3;
    localparam int SUM_W    = 21;
    localparam int NUM_REGS = 8;
    localparam int CNT_W    = 4;

    localparam logic [CNT_W-1:0] MAX_COUNT = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Requests beyond the register file size read each register once.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt > MAX_COUNT) begin
            res = MAX_COUNT;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/regc_accum.sv
// Running-sum and last-sample registers for the sweep datapath.
// Clear has priority over enable.
module regc_accum #(
    parameter int DW = regc_pkg::DATA_W,
    parameter int SW = regc_pkg::SUM_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [SW-1:0] sum_o,
    output logic [DW-1:0] last_o
);

    logic [SW-1:0] sum_q;
    logic [DW-1:0] last_q;
    logic [SW-1:0] data_ext_s;

    assign data_ext_s = {{(SW-DW){1'b0}}, data_i};

    // Accumulate zero-extended samples; clear on a newly accepted sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= {SW{1'b0}};
            last_q <= {DW{1'b0}};
        end else if (clr_i) begin
            sum_q  <= {SW{1'b0}};
            last_q <= {DW{1'b0}};
        end else if (en_i) begin
            sum_q  <= sum_q + data_ext_s;
            last_q <= data_i;
        end
    end

    assign sum_o  = sum_q;
    assign last_o = last_q;

endmodule

// File: rtl/regc_sweep_sequencer.sv
// Walks a run of consecutive register-C mux addresses, asserting swap1 while
// reading, accumulating the returned values and pulsing done at the end.
module regc_sweep_sequencer #(
    parameter int DATA_W = regc_pkg::DATA_W,
    parameter int ADDR_W = regc_pkg::ADDR_W,
    parameter int SUM_W  = regc_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        count,
    input  logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              swap1,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] last
);

    import regc_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        rem_q, rem_d;
    logic              swap1_q, busy_q, done_q;
    logic              acc_clr_s, acc_en_s;
    logic [3:0]        cnt_clamped_s;

    assign cnt_clamped_s = clamp_count(count);

    // Next-state, address and remaining-count logic; abort always wins.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        acc_clr_s = 1'b0;
        acc_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d    = base_addr;
                    rem_d     = cnt_clamped_s;
                    acc_clr_s = 1'b1;
                    if (cnt_clamped_s != 4'd0) begin
                        state_d = SWEEP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_en_s = 1'b1;
                    addr_d   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rem_d    = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = SWEEP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counters; the status flags are decoded from the next state
    // so each one is a flop aligned with the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            rem_q   <= 4'd0;
            swap1_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            swap1_q <= (state_d == SWEEP);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    regc_accum #(
        .DW (DATA_W),
        .SW (SUM_W)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr_s),
        .en_i   (acc_en_s),
        .data_i (bus),
        .sum_o  (sum),
        .last_o (last)
    );

    assign reg_addr = addr_q;
    assign swap1    = swap1_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_regc_sweep_sequencer.sv
// Randomized bench for regc_sweep_sequencer with a per-sweep reference model
// derived from the cycle-numbered behaviour of a sweep.
module tb_regc_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  base_addr = 3'd0;
    logic [3:0]  count = 4'd0;
    logic [17:0] bus;
    logic [2:0]  reg_addr;
    logic        swap1, busy, done;
    logic [20:0] sum;
    logic [17:0] last;

    logic [17:0] mem [8];
    int n_tests = 0;
    int n_fail  = 0;

    assign bus = mem[reg_addr];

    always #5 clk = ~clk;

    regc_sweep_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .count     (count),
        .bus       (bus),
        .reg_addr  (reg_addr),
        .swap1     (swap1),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .last      (last)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, ".addr"},  {29'd0, reg_addr}, 32'd0);
        check_val({tag, ".swap1"}, {31'd0, swap1},    32'd0);
        check_val({tag, ".busy"},  {31'd0, busy},     32'd0);
        check_val({tag, ".done"},  {31'd0, done},     32'd0);
        check_val({tag, ".sum"},   {11'd0, sum},      32'd0);
        check_val({tag, ".last"},  {14'd0, last},     32'd0);
    endtask

    // Called at a negedge with the DUT idle. abort_at = k aborts during read
    // cycle k (0 = no abort). noise toggles start during the sweep.
    task automatic do_sweep(input int base, input int cnt, input int abort_at, input bit noise);
        int n;
        int a;
        int exp_sum;
        int exp_last;
        n = (cnt > 8) ? 8 : cnt;
        exp_sum = 0;
        exp_last = 0;
        base_addr = base[2:0];
        count = cnt[3:0];
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            a = (base + k - 1) % 8;
            check_val("sw.swap1", {31'd0, swap1}, 32'd1);
            check_val("sw.addr",  {29'd0, reg_addr}, a);
            check_val("sw.busy",  {31'd0, busy}, 32'd1);
            check_val("sw.done",  {31'd0, done}, 32'd0);
            if (k == abort_at) begin
                abort = 1'b1;
                start = noise ? 1'(($urandom % 2)) : 1'b0;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check_val("ab.busy",  {31'd0, busy}, 32'd0);
                check_val("ab.swap1", {31'd0, swap1}, 32'd0);
                check_val("ab.done",  {31'd0, done}, 32'd0);
                check_val("ab.sum",   {11'd0, sum}, exp_sum);
                check_val("ab.last",  {14'd0, last}, exp_last);
                check_val("ab.addr",  {29'd0, reg_addr}, a);
                @(negedge clk);
                check_val("ab.nodone", {31'd0, done}, 32'd0);
                return;
            end
            exp_sum += int'(mem[a]);
            exp_last = int'(mem[a]);
            if (noise) start = 1'(($urandom % 2));
            @(negedge clk);
        end
        check_val("dn.done",  {31'd0, done}, 32'd1);
        check_val("dn.busy",  {31'd0, busy}, 32'd1);
        check_val("dn.swap1", {31'd0, swap1}, 32'd0);
        check_val("dn.sum",   {11'd0, sum}, exp_sum);
        check_val("dn.last",  {14'd0, last}, exp_last);
        check_val("dn.addr",  {29'd0, reg_addr}, (base + n) % 8);
        start = noise ? 1'(($urandom % 2)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_val("id.done", {31'd0, done}, 32'd0);
        check_val("id.busy", {31'd0, busy}, 32'd0);
        check_val("id.sum",  {11'd0, sum}, exp_sum);
        check_val("id.last", {14'd0, last}, exp_last);
    endtask

    initial begin
        int b, c, ab, nn;
        for (int i = 0; i < 8; i++) mem[i] = 18'd0;

        // Reset and idle.
        repeat (2) @(negedge clk);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("idle.swap1", {31'd0, swap1}, 32'd0);
        end

        // Basic sweep.
        mem[1] = 18'd100; mem[2] = 18'd200; mem[3] = 18'd300;
        do_sweep(1, 3, 0, 1'b0);
        check_val("basic.sum", {11'd0, sum}, 32'd600);

        // Wrap and full scale.
        for (int i = 0; i < 8; i++) mem[i] = 18'h3FFFF;
        do_sweep(6, 8, 0, 1'b0);
        check_val("full.sum", {11'd0, sum}, 32'h1FFFF8);

        // Clamp and zero count.
        for (int i = 0; i < 8; i++) mem[i] = 18'($urandom);
        do_sweep(3, 12, 0, 1'b0);
        do_sweep(5, 0, 0, 1'b0);
        check_val("zero.sum", {11'd0, sum}, 32'd0);

        // Abort in cycle 3 of a count-5 sweep from address 0.
        do_sweep(0, 5, 3, 1'b0);
        check_val("abort.sum", {11'd0, sum}, int'(mem[0]) + int'(mem[1]));

        // start together with abort in IDLE does nothing.
        start = 1'b1; abort = 1'b1; base_addr = 3'd2; count = 4'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_val("blk.busy",  {31'd0, busy}, 32'd0);
        check_val("blk.swap1", {31'd0, swap1}, 32'd0);
        @(negedge clk);

        // Back-to-back with start held: one idle cycle between sweeps.
        base_addr = 3'd2; count = 4'd2; start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("b2b.done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check_val("b2b.gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_val("b2b.swap1", {31'd0, swap1}, 32'd1);
        check_val("b2b.addr", {29'd0, reg_addr}, 32'd2);
        repeat (3) @(negedge clk);
        check_val("b2b.end", {31'd0, busy}, 32'd0);

        // Randomized sweeps with ignored start noise and occasional aborts.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 8; i++) mem[i] = 18'($urandom);
            b = $urandom_range(0, 7);
            c = $urandom_range(0, 15);
            nn = (c > 8) ? 8 : c;
            ab = 0;
            if (nn > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, nn);
            do_sweep(b, c, ab, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) mem[i] = 18'd7;
        base_addr = 3'd4; count = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid.busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post.swap1", {31'd0, swap1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regc_sweep_sequencer.md
# regc_sweep_sequencer

Sequencer that sits directly upstream of the register-C read mux. It drives `reg_addr` and `swap1`, walks a programmed run of consecutive registers (R13..R19, R), and accumulates the 18-bit values returned on `bus` into a running sum for the down-sampling datapath. It signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- DATA_W, 18, width of `bus` and of each register
- ADDR_W, 3, width of `reg_addr` (8 registers)
- SUM_W, 21, accumulator width (DATA_W + ADDR_W, so 8 full-scale values cannot overflow)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  terminate a sweep in progress
- base_addr  in  ADDR_W  first register address, latched on accepted start
- count  in  4  number of registers to read (0..8; values 9..15 clamp to 8), latched on accepted start
- bus  in  DATA_W  value selected by the mux for the current `reg_addr`
- reg_addr  out  ADDR_W  registered address to the mux
- swap1  out  1  registered read-enable to the mux
- busy  out  1  high from the cycle after an accepted start until `done` completes or abort
- done  out  1  one-cycle completion pulse
- sum  out  SUM_W  accumulated total of the values read
- last  out  DATA_W  most recently captured `bus` value

## Operation
- States: IDLE, SWEEP, DONE. All outputs are registered.
- IDLE: if `start` and not `abort` → latch `base_addr` into `reg_addr`, latch clamped `count` into `remaining`, clear `sum` and `last`. Go to SWEEP if count ≥ 1, otherwise go to DONE.
- SWEEP: `swap1`=1 and `busy`=1. On each edge: `sum` += zero-extended `bus`; `last` ← `bus`; `reg_addr` ← `reg_addr`+1 mod 8 (7 wraps to 0); `remaining` −1. When `remaining`==1 at an edge → DONE.
- DONE: `swap1`=0, `busy`=1, `done`=1 for exactly one cycle, then IDLE.
- abort in SWEEP or DONE → IDLE next edge. `swap1`, `busy` and `done` go to 0. `sum`/`last` keep their partial values and no `done` pulse is produced. abort in IDLE has no effect and blocks `start` that cycle.
- `start` while not in IDLE is ignored, with no queuing.
- `reg_addr` holds its last value in IDLE/DONE. The mux still decodes it to `enC` while `swap1`=0, and that is acceptable.
- `sum`/`last` hold their values after DONE until the next accepted start.

## Timing
- Reset (async assert, synchronous release): state IDLE, `reg_addr`=0, `swap1`=0, `busy`=0, `done`=0, `sum`=0, `last`=0, `remaining`=0.
- The mux is combinational, so `bus` is valid in the same cycle `swap1`/`reg_addr` are presented and is captured at the closing edge. There are zero wait states.
- For start accepted at edge 0 with count N ≥ 1:
  - cycles 1..N: `swap1`=1
  - cycle N+1: `done`=1
  - cycles 1..N+1: `busy`=1
  - after edge N: `sum` is final and stable while `done` is high
- count 0: cycle 1 has `busy`=1 and `done`=1, `swap1` is never asserted, and `sum`=0.
- Back-to-back: `start` held high re-arms in the first IDLE cycle after DONE, giving one idle cycle between sweeps.
- Reset mid-sweep: all outputs return to reset values immediately on `rst_n` low.

## Structure
- Shared package `regc_pkg` holds:
  - DATA_W, ADDR_W, SUM_W, NUM_REGS=8
  - state enum (IDLE, SWEEP, DONE)
  - the count-clamp constant MAX_COUNT=8
- One sub-module, `regc_accum`, holds the `sum`/`last` registers with clear and enable inputs. The FSM, address counter and remaining counter stay in the top level.

## Test plan
- Reset then idle: `rst_n` low mid-cycle → all outputs 0 asynchronously; after release with no start, `swap1` stays 0.
- Basic sweep: base_addr=1, count=3, bus returns 100/200/300 for addr 1/2/3 → `reg_addr` 1,2,3 over cycles 1–3, `done` in cycle 4, `sum`=600, `last`=300.
- Wrap and full scale: base_addr=6, count=8, bus=18'h3FFFF for all addresses → addr sequence 6,7,0,1,2,3,4,5; `sum`=21'h1FFFF8 with no overflow.
- Clamp and zero: count=12 behaves exactly as count=8. count=0 → `done` in cycle 1, `sum`=0, `swap1` never high.
- Abort: base_addr=0, count=5, abort in cycle 3 → IDLE next edge, no `done`, `sum` equals the values of addr 0,1 (and 2 if captured at that edge), `busy`=0.
- Ignored start and priority: pulse `start` during SWEEP → no effect on sequence. `start`+`abort` together in IDLE → no sweep.
